// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - NUM_CH SRAM-like request channels bridged onto one AXI3 master port
//
// One transaction is in flight at a time. Idle requesters are arbitrated
// round-robin, and the winning channel index is used as the AXI ID.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   ch_req/ch_wr/ch_burst          per-channel request, write select, line-read select
//   ch_size/ch_addr/ch_wdata       per-channel packed size (2b), byte address, write data
//   ch_rdata                       shared read data, qualified by ch_data_ok
//   ch_addr_ok/ch_data_ok          per-channel accept pulse / beat-or-write-done pulse
//   ar*/r*/aw*/w*/b*               AXI3 master, 4-bit IDs, 32-bit address and data
//
// Build option: SRAM_AXI_BURST_EN enables LINE_WORDS-beat INCR line reads
// on ch_burst; without it every read is a single beat.

module sram_axi_bridge #(
   parameter int NUM_CH     = 2,
   parameter int LINE_WORDS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     ch_req,
   input  logic [NUM_CH-1:0]     ch_wr,
   input  logic [NUM_CH-1:0]     ch_burst,
   input  logic [2*NUM_CH-1:0]   ch_size,
   input  logic [32*NUM_CH-1:0]  ch_addr,
   input  logic [32*NUM_CH-1:0]  ch_wdata,
   output logic [31:0]           ch_rdata,
   output logic [NUM_CH-1:0]     ch_addr_ok,
   output logic [NUM_CH-1:0]     ch_data_ok,
   output logic [3:0]            arid,
   output logic [31:0]           araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [1:0]            arlock,
   output logic [3:0]            arcache,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [3:0]            rid,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [3:0]            awid,
   output logic [31:0]           awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [1:0]            awlock,
   output logic [3:0]            awcache,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [3:0]            wid,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [3:0]            bid,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR_DATA,
      WR_RESP
   } state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   owner;
   logic [GW-1:0]   grant_idx;
   logic [GW-1:0]   cand_idx;
   logic            grant_vld;
   int              cand;
   logic [1:0]      size_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic            aw_done;
   logic            w_done;
   logic            addr_ok_cyc;
   logic [3:0]      id;

   // Scan channels starting just above last_grant, wrapping at NUM_CH;
   // the first requester found wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_CH) cand = cand - NUM_CH;
         cand_idx = GW'(cand);
         if (!grant_vld && ch_req[cand_idx]) begin
            grant_vld = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // The addr_ok cycle is the first cycle of RD_ADDR / WR_ADDR_DATA; the
   // AXI valids are held off for it so they follow addr_ok by one cycle.
   assign addr_ok_cyc = |ch_addr_ok;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) state_nxt = ch_wr[grant_idx] ? WR_ADDR_DATA : RD_ADDR;
         end
         RD_ADDR: begin
            arvalid = !addr_ok_cyc;
            if (arvalid && arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid && rlast) state_nxt = IDLE;
         end
         WR_ADDR_DATA: begin
            awvalid = !addr_ok_cyc && !aw_done;
            wvalid  = !addr_ok_cyc && !w_done;
            if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)))
               state_nxt = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GW'(NUM_CH - 1);
         owner      <= '0;
         size_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         ch_addr_ok <= '0;
         ch_data_ok <= '0;
         ch_rdata   <= '0;
      end else begin
         ch_addr_ok <= '0;
         ch_data_ok <= '0;
         if (state == IDLE && grant_vld) begin
            owner                 <= grant_idx;
            last_grant            <= grant_idx;
            ch_addr_ok[grant_idx] <= 1'b1;
            size_q                <= ch_size[2*grant_idx +: 2];
            addr_q                <= ch_addr[32*grant_idx +: 32];
            wdata_q               <= ch_wdata[32*grant_idx +: 32];
            aw_done               <= 1'b0;
            w_done                <= 1'b0;
         end
         if (awvalid && awready) aw_done <= 1'b1;
         if (wvalid && wready)   w_done  <= 1'b1;
         if (rvalid && rready) begin
            ch_rdata          <= rdata;
            ch_data_ok[owner] <= 1'b1;
         end
         if (bvalid && bready) ch_data_ok[owner] <= 1'b1;
      end
   end

   assign id = 4'(owner);

`ifdef SRAM_AXI_BURST_EN
   localparam int LB = $clog2(4 * LINE_WORDS);

   logic burst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         burst_q <= 1'b0;
      end else if (state == IDLE && grant_vld) begin
         burst_q <= ch_burst[grant_idx] & ~ch_wr[grant_idx];
      end
   end

   // Line refills start at the line base so beats return in address order.
   assign araddr = burst_q ? {addr_q[31:LB], {LB{1'b0}}} : addr_q;
   assign arlen  = burst_q ? 8'(LINE_WORDS - 1) : 8'd0;
   assign arsize = burst_q ? 3'd2 : {1'b0, size_q};

   logic unused_ok;
   assign unused_ok = ^{rid, bid, rresp, bresp};
`else
   assign araddr = addr_q;
   assign arlen  = 8'd0;
   assign arsize = {1'b0, size_q};

   logic unused_ok;
   assign unused_ok = ^{rid, bid, rresp, bresp, ch_burst};
`endif

   assign arid    = id;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   assign awid    = id;
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;

   assign wid     = id;
   assign wdata   = wdata_q;
   assign wlast   = 1'b1;

   always_comb begin
      case (size_q)
         2'd0:    wstrb = 4'b0001 << addr_q[1:0];
         2'd1:    wstrb = 4'b0011 << addr_q[1:0];
         default: wstrb = 4'b1111;
      endcase
   end

endmodule
